// File: rtl/wb_slot_scheduler_pkg.sv
// Shared types and default latencies for the writeback slot scheduler.
package wb_slot_scheduler_pkg;

   typedef enum logic [1:0] {
      UNIT_ALU  = 2'd0,
      UNIT_MEM  = 2'd1,
      UNIT_MUL  = 2'd2,
      UNIT_NONE = 2'd3
   } unit_e;

   typedef struct packed {
      logic       valid;
      unit_e      unit;
      logic [4:0] regdest;
      logic       writereg;
   } entry_t;

   localparam int unsigned DEF_LAT_ALU = 1;
   localparam int unsigned DEF_LAT_MEM = 2;
   localparam int unsigned DEF_LAT_MUL = 4;
   localparam int unsigned DEF_MAX_LAT = 4;

endpackage

// File: rtl/wb_slot_scheduler_hazard.sv
// Combinational RAW/WAW check of an issuing instruction against all pending writebacks.
module wb_hazard_check
   import wb_slot_scheduler_pkg::*;
#(
   parameter int unsigned MAX_LAT = DEF_MAX_LAT
) (
   input  logic [4:0] i_rs,
   input  logic [4:0] i_rt,
   input  logic [4:0] i_regdest,
   input  logic       i_writereg,
   input  entry_t     i_res [1:MAX_LAT],
   output logic       o_raw_hit,
   output logic       o_waw_hit
);

   always_comb begin
      o_raw_hit = 1'b0;
      o_waw_hit = 1'b0;
      // Only entries that really write a non-zero register are pending; r0 can never match.
      for (int unsigned k = 1; k <= MAX_LAT; k++) begin
         if (i_res[k].valid && i_res[k].writereg && (i_res[k].regdest != 5'd0)) begin
            if ((i_rs == i_res[k].regdest) || (i_rt == i_res[k].regdest))
               o_raw_hit = 1'b1;
            if (i_writereg && (i_regdest == i_res[k].regdest))
               o_waw_hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wb_slot_scheduler.sv
// Reserves writeback slots at dispatch, stalls on slot collision or RAW/WAW,
// and drives the shared writeback port straight from the head of the reservation shift array.
module wb_slot_scheduler
   import wb_slot_scheduler_pkg::*;
#(
   parameter int unsigned LAT_ALU = DEF_LAT_ALU,
   parameter int unsigned LAT_MEM = DEF_LAT_MEM,
   parameter int unsigned LAT_MUL = DEF_LAT_MUL,
   parameter int unsigned MAX_LAT = DEF_MAX_LAT
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       issue_valid,
   input  logic [1:0] issue_unit,
   input  logic [4:0] issue_rs,
   input  logic [4:0] issue_rt,
   input  logic [4:0] issue_regdest,
   input  logic       issue_writereg,
   output logic       issue_stall,
   output logic       dispatch_alu,
   output logic       dispatch_mem,
   output logic       dispatch_mul,
   output logic       wb_valid,
   output logic [1:0] wb_unit,
   output logic [4:0] wb_regdest,
   output logic       wb_writereg
);

   if ((LAT_ALU == 0) || (LAT_MEM == 0) || (LAT_MUL == 0) ||
       (LAT_ALU > MAX_LAT) || (LAT_MEM > MAX_LAT) || (LAT_MUL > MAX_LAT)) begin : g_bad_latency
      $error("wb_slot_scheduler: every LAT_* must be in 1..MAX_LAT");
   end

   entry_t      r_res [1:MAX_LAT];
   int unsigned w_lat;
   logic        w_slot_busy;
   logic        w_raw_hit;
   logic        w_waw_hit;
   logic        w_dispatch;
   entry_t      w_new_entry;

   wb_hazard_check #(
      .MAX_LAT (MAX_LAT)
   ) u_hazard (
      .i_rs       (issue_rs),
      .i_rt       (issue_rt),
      .i_regdest  (issue_regdest),
      .i_writereg (issue_writereg),
      .i_res      (r_res),
      .o_raw_hit  (w_raw_hit),
      .o_waw_hit  (w_waw_hit)
   );

   always_comb begin
      case (issue_unit)
         UNIT_ALU: w_lat = LAT_ALU;
         UNIT_MEM: w_lat = LAT_MEM;
         UNIT_MUL: w_lat = LAT_MUL;
         default:  w_lat = 0;
      endcase
      // Target slot L is fed by res[L+1] on this edge; a valid one there means collision.
      w_slot_busy = 1'b0;
      for (int unsigned k = 1; k < MAX_LAT; k++) begin
         if ((w_lat == k) && r_res[k+1].valid)
            w_slot_busy = 1'b1;
      end
   end

   assign issue_stall  = reset ||
                         (issue_valid && (issue_unit != UNIT_NONE) &&
                          (w_slot_busy || w_raw_hit || w_waw_hit));
   assign dispatch_alu = issue_valid && !issue_stall && (issue_unit == UNIT_ALU);
   assign dispatch_mem = issue_valid && !issue_stall && (issue_unit == UNIT_MEM);
   assign dispatch_mul = issue_valid && !issue_stall && (issue_unit == UNIT_MUL);
   assign w_dispatch   = dispatch_alu || dispatch_mem || dispatch_mul;

   assign w_new_entry = '{valid:    1'b1,
                          unit:     unit_e'(issue_unit),
                          regdest:  issue_regdest,
                          writereg: issue_writereg};

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned k = 1; k <= MAX_LAT; k++)
            r_res[k] <= '0;
      end else begin
         for (int unsigned k = 1; k < MAX_LAT; k++)
            r_res[k] <= r_res[k+1];
         r_res[MAX_LAT] <= '0;
         for (int unsigned k = 1; k <= MAX_LAT; k++) begin
            if (w_dispatch && (w_lat == k))
               r_res[k] <= w_new_entry;
         end
      end
   end

   // Invalid entries are always all-zero, so the head can drive the port unmasked.
   assign wb_valid    = r_res[1].valid;
   assign wb_unit     = r_res[1].unit;
   assign wb_regdest  = r_res[1].regdest;
   assign wb_writereg = r_res[1].writereg;

endmodule

// File: doc/wb_slot_scheduler.md
Name: wb_slot_scheduler

Overview:
Issue-side scheduler for the multi-latency execute stage. ALU results take 1 cycle, memory results 2 cycles and multiply (4-stage M pipe) 4 cycles. All three share one writeback port (regdest/writereg/wbvalue). The block reserves writeback slots at dispatch, stalls issue on slot collision or RAW/WAW hazards, and drives the per-cycle writeback mux select.

Parameters:
LAT_ALU, 1, ALU result latency in cycles (dispatch to writeback)
LAT_MEM, 2, memory-path latency
LAT_MUL, 4, multiply-path latency
MAX_LAT, 4, reservation depth; must be >= every LAT_* (elaboration error otherwise)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
issue_valid  in  1  decoded instruction present
issue_unit  in  2  0=ALU, 1=MEM, 2=MUL, 3=none (nop; no slot reserved)
issue_rs  in  5  source register A
issue_rt  in  5  source register B
issue_regdest  in  5  destination register
issue_writereg  in  1  instruction writes regdest
issue_stall  out  1  combinational; instruction held this cycle
dispatch_alu  out  1  one-hot dispatch strobe to ALU
dispatch_mem  out  1  dispatch strobe to memory path
dispatch_mul  out  1  dispatch strobe to multiply path
wb_valid  out  1  writeback slot occupied this cycle
wb_unit  out  2  unit whose result drives the writeback mux
wb_regdest  out  5  destination of the current writeback
wb_writereg  out  1  register-file write enable

Behaviour:
- State: reservation array res[1..MAX_LAT]; each entry holds {valid, unit[1:0], regdest[4:0], writereg}.
- res[k] means "writes back k cycles from now". wb_* outputs are driven directly from res[1] with no extra register stage.
- Every edge: res[k] <= res[k+1] for k < MAX_LAT; res[MAX_LAT] <= empty.
- Latency: L = LAT_{unit}. On dispatch at cycle t, the entry is written into res[L] at the same edge. This overrides the shift into that slot. wb_valid for the instruction is asserted exactly in cycle t+L.
- Slot collision: slot_busy = (L < MAX_LAT) && res[L+1].valid, i.e. the slot L would occupy after the shift.
- Hazards use P = every valid entry with writereg=1 and regdest != 0.
  - RAW: issue_rs or issue_rt equals a regdest in P. Register 0 never hazards.
  - WAW: issue_writereg && issue_regdest != 0 && issue_regdest equals a regdest in P.
  - res[1] counts as pending. The register file writes at end of cycle, so there is no same-cycle bypass.
- issue_stall = issue_valid && unit != 3 && (slot_busy || RAW || WAW).
- Dispatch strobes: dispatch_x = issue_valid && !issue_stall && issue_unit == x, for exactly one cycle. Unit 3 issues with no strobe and no reservation.
- wb_unit/wb_regdest/wb_writereg are 0 when wb_valid=0.
- Reset (synchronous, any time, including mid-flight): all res entries invalid, so every output is 0 in the cycle after reset. In-flight results are dropped; downstream units must be reset with the same signal. While reset=1, issue_stall=1 and all dispatch strobes=0.
- Simultaneous events:
  - A dispatch into res[L] and the shift both target slot L. The dispatch wins; collision detection guarantees the shifted value is empty.
  - A new entry and the res[1] writeback in the same cycle are legal.
- Stall is combinational from inputs and state. Upstream holds the instruction stable while stalled.

Decomposition:
- Shared package:
  - unit encodings (UNIT_ALU/MEM/MUL/NONE)
  - entry struct (valid, unit, regdest, writereg)
  - default latency constants
- One natural sub-module: wb_hazard_check. It compares rs/rt/regdest against all MAX_LAT entries and returns raw_hit and waw_hit; it is purely combinational.
- The reservation array and shift logic stay in the top module.

Test Plan:
- Single MUL dispatch at cycle 0 (regdest=5, writereg=1) -> dispatch_mul=1 at cycle 0; wb_valid=1, wb_unit=2, wb_regdest=5 only at cycle 4.
- MUL at cycle 0, then MEM at cycle 2 (LAT 2, target slot = cycle 4) -> issue_stall=1 at cycle 2 (collision); MEM dispatches at cycle 3 and writes back at cycle 5.
- MUL rd=7 at cycle 0, then ALU with rs=7 at cycle 1 -> stall cycles 1-4 (res[1] still pending at cycle 4); ALU dispatches at cycle 5.
- WAW: MUL rd=3 then ALU rd=3 (rs/rt=0) the next cycle -> stalled until the MUL writeback cycle has passed. Writebacks occur in program order, never ALU before MUL.
- Register 0: MUL rd=0 then ALU rs=0 -> no stall; ALU writes back at cycle 2 and MUL at cycle 4.
- Reset asserted at cycle 2 with MUL and MEM in flight -> from cycle 3 wb_valid=0 permanently until new dispatch; no stale writeback at cycles 4/5.
